// File: rtl/div_seq_pkg.sv
// Shared constants and state encoding for the iterative divider and the ALU that drives it.
package div_seq_pkg;

    localparam int DIV_W = 32;

    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/div_seq_if.sv
// Request/response bundle between the execute-stage ALU (master) and the divider (slave).
interface div_seq_if;
    import div_seq_pkg::*;

    logic                 signed_div_i;
    logic [DIV_W-1:0]     opdata1_i;
    logic [DIV_W-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*DIV_W-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );

endinterface

// File: rtl/div_seq_abs.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module div_abs
    import div_seq_pkg::*;
(
    input  logic [DIV_W-1:0] i_val,
    input  logic             i_neg,
    output logic [DIV_W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + 1'b1) : i_val;

endmodule

// File: rtl/div_seq.sv
// Restoring one-bit-per-cycle 32-bit DIV/DIVU with annul; result is {remainder, quotient}.
// Optional macro DIV_EARLY_OUT_EN finishes in one cycle when |dividend| < |divisor|.
module div_seq
    import div_seq_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);

    div_state_t           r_state;
    logic [5:0]           r_cnt;
    logic [DIV_W:0]       r_rem;
    logic [DIV_W-1:0]     r_quo;
    logic [DIV_W-1:0]     r_absb;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [2*DIV_W-1:0]   r_result;
    logic                 r_ready;
    logic                 r_busy;

    logic                 w_sgn_a;
    logic                 w_sgn_b;
    logic [DIV_W-1:0]     w_abs_a;
    logic [DIV_W-1:0]     w_abs_b;
    logic [DIV_W+1:0]     w_diff;
    logic                 w_borrow;
    logic [DIV_W:0]       w_rem_nxt;
    logic [DIV_W-1:0]     w_quo_nxt;
    logic [DIV_W-1:0]     w_rem_fix;
    logic [DIV_W-1:0]     w_quo_fix;

    assign w_sgn_a = bus.signed_div_i & bus.opdata1_i[DIV_W-1];
    assign w_sgn_b = bus.signed_div_i & bus.opdata2_i[DIV_W-1];

    div_abs u_abs_a (.i_val(bus.opdata1_i), .i_neg(w_sgn_a), .o_val(w_abs_a));
    div_abs u_abs_b (.i_val(bus.opdata2_i), .i_neg(w_sgn_b), .o_val(w_abs_b));

    // Shift {rem, quo} left and trial-subtract; a borrow means restore.
    assign w_diff    = {r_rem, r_quo[DIV_W-1]} - {2'b00, r_absb};
    assign w_borrow  = w_diff[DIV_W+1];
    assign w_rem_nxt = w_borrow ? {r_rem[DIV_W-1:0], r_quo[DIV_W-1]} : w_diff[DIV_W:0];
    assign w_quo_nxt = {r_quo[DIV_W-2:0], ~w_borrow};

    div_abs u_fix_r (.i_val(w_rem_nxt[DIV_W-1:0]), .i_neg(r_neg_r), .o_val(w_rem_fix));
    div_abs u_fix_q (.i_val(w_quo_nxt),            .i_neg(r_neg_q), .o_val(w_quo_fix));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= DIV_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    r_ready <= 1'b0;
                    if (bus.start_i == DivStart && bus.annul_i == DivStop) begin
                        r_neg_q <= w_sgn_a ^ w_sgn_b;
                        r_neg_r <= w_sgn_a;
                        r_absb  <= w_abs_b;
                        r_quo   <= w_abs_a;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        if (bus.opdata2_i == '0) begin
                            r_state  <= DIV_DONE;
                            r_ready  <= 1'b1;
                            r_result <= {bus.opdata1_i, {DIV_W{1'b1}}};
`ifdef DIV_EARLY_OUT_EN
                        end else if (w_abs_a < w_abs_b) begin
                            r_state  <= DIV_DONE;
                            r_ready  <= 1'b1;
                            r_result <= {bus.opdata1_i, {DIV_W{1'b0}}};
`endif
                        end else begin
                            r_state <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (bus.annul_i) begin
                        // Flush: drop the work, leave the previous result visible.
                        r_state <= DIV_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'(DIV_W - 1)) begin
                            r_state  <= DIV_DONE;
                            r_ready  <= 1'b1;
                            r_result <= {w_rem_fix, w_quo_fix};
                        end
                    end
                end
                DIV_DONE: begin
                    r_state <= DIV_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= DIV_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;
    assign bus.busy_o   = r_busy;

endmodule

// File: doc/div_seq.md
# div_seq

Iterative 32-bit divider feeding the execute-stage ALU's 64-bit HI/LO result path. The ALU raises `start_i` with the operands and stalls the pipeline until `ready_o`. The block then supplies `{remainder, quotient}` in HI/LO order. It handles signed (DIV) and unsigned (DIVU) division with a one-bit-per-cycle restoring algorithm, and supports annulment on a pipeline flush.

## Interface
- No parameters; data width is fixed at 32 (constant `DIV_W` in `defines.vh`).
- `clk`  in  1  pipeline clock
- `rst`  in  1  synchronous, active-low reset
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- `opdata1_i`  in  32  dividend; sampled with start
- `opdata2_i`  in  32  divisor; sampled with start
- `start_i`  in  1  request; accepted only in IDLE
- `annul_i`  in  1  abort an in-flight division (flush/exception)
- `result_o`  out  64  `{remainder[31:0], quotient[31:0]}`
- `ready_o`  out  1  result valid pulse
- `busy_o`  out  1  high in any state other than IDLE

## Operation
- Reset: `rst`=0 at a clock edge sets IDLE, `result_o`=0, `ready_o`=0, `busy_o`=0. Reset mid-division discards all work.
- States:
  - IDLE: wait for a start.
  - BUSY: iterate.
  - DONE: assert `ready_o` for one cycle, then return to IDLE.
- IDLE with `start_i`=1 and `annul_i`=0:
  - Latch operands and the signedness flag.
  - Record the sign of the quotient (`a[31]^b[31]`) and of the remainder (`a[31]`); signed mode only.
  - Form absolute values (two's-complement negate when the sign bit is set in signed mode).
  - Clear the 6-bit counter, clear the partial remainder, go to BUSY.
- Divisor == 0: go straight to DONE with quotient 0xFFFFFFFF and remainder = raw dividend, regardless of sign.
- BUSY iteration:
  - Shift `{rem, quo}` left by 1.
  - Trial-subtract the absolute divisor from the 33-bit partial remainder.
  - If non-negative, keep the difference and set quo LSB=1; otherwise restore.
  - Increment the counter; after iteration 32, go to DONE.
- Entering DONE:
  - Apply sign fix-up: negate the quotient if its recorded sign is 1; negate the remainder if its recorded sign is 1.
  - Register the value into `result_o`.
- `result_o` holds its value until the next accepted start; it does not clear on DONE→IDLE.
- Overflow case −2^31 / −1: quotient 0x80000000, remainder 0. This is wrap behaviour; no trap is raised.
- `annul_i`=1 in BUSY: go to IDLE next edge, `ready_o` is never asserted, `result_o` is unchanged.
- `annul_i` in DONE: `ready_o` still pulses; the consumer ignores it.
- `start_i` in BUSY or DONE is ignored. A start held high after DONE launches a new division from IDLE; the consumer drops start when it sees `ready_o`.
- Simultaneous `start_i` and `annul_i` in IDLE: annul wins and no division starts.

## Timing
- Start sampled at the edge ending cycle 0.
- Iterations run on the edges ending cycles 1..32.
- `ready_o`=1 throughout cycle 33; `busy_o`=1 cycles 1..33.
- Divide-by-zero: `ready_o` in cycle 1.
- `result_o` is valid in the same cycle as `ready_o`.
- Back-to-back: the earliest next start is sampled at the end of cycle 34 (IDLE).
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `DIV_EARLY_OUT_EN`:
  - Defined: in IDLE, when `|dividend| < |divisor|` (non-zero divisor), go directly to DONE with quotient 0 and remainder = raw dividend. `ready_o` appears in cycle 1.
  - Undefined: every non-zero-divisor division takes the full 33-cycle latency.
- Results are identical either way; only latency differs.

## Structure
- `defines.vh` holds:
  - `DIV_W`
  - the state encodings `DIV_IDLE`, `DIV_BUSY`, `DIV_DONE` (2-bit)
  - `DivStart`/`DivStop`, shared with the ALU
- One natural sub-module, `div_abs`: a 32-bit conditional two's-complement negate. Instantiate it for operand absolute values and for result sign fix-up.
- The datapath is a 65-bit `{rem, quo}` shift register plus a 33-bit subtractor; the control is the 3-state FSM plus a 6-bit counter.

## Test plan
- Unsigned 100 / 7, start one cycle → cycle 33 `ready_o`=1, `result_o`=`{32'd2, 32'd14}`, `busy_o` low in cycle 34.
- Signed −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 1. Signed 0x80000000 / 0xFFFFFFFF → `{0, 0x80000000}`.
- Divisor 0 with dividend 0x12345678 → `ready_o` in cycle 1, `result_o`=`{0x12345678, 0xFFFFFFFF}`.
- `annul_i` pulsed in cycle 10 of a division → IDLE in cycle 11, no `ready_o`, `result_o` keeps its prior value; a new start in cycle 12 completes normally 33 cycles later.
- `rst`=0 in cycle 20 of a division → outputs 0 next cycle. Start held high through DONE → second division begins, second `ready_o` at cycle 67.
- With `DIV_EARLY_OUT_EN` defined: 3 / 10 unsigned → `ready_o` in cycle 1, `{3, 0}`. With it undefined → same result in cycle 33.
